// File: rtl/gate_arb_pkg.sv
// Shared types and constants for the gate unit arbiter.
//   gate_op_e   : 3-bit opcode of the shared bitwise gate unit
//   arb_state_e : arbiter FSM states (idle / execute / respond)
//   OP_W        : opcode width
package gate_arb_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OpNot  = 3'd0,
        OpBuf  = 3'd1,
        OpAnd  = 3'd2,
        OpOr   = 3'd3,
        OpNand = 3'd4,
        OpNor  = 3'd5,
        OpXor  = 3'd6,
        OpXnor = 3'd7
    } gate_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } arb_state_e;

endpackage

// File: rtl/basic_gate_alu.sv
// Combinational bitwise gate unit.
//   op     : gate opcode (NOT/BUF ignore b)
//   a, b   : DATA_W-bit operands
//   result : DATA_W-bit bitwise result
module basic_gate_alu
    import gate_arb_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  gate_op_e          op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = '0;
        unique case (op)
            OpNot:   result = ~a;
            OpBuf:   result = a;
            OpAnd:   result = a & b;
            OpOr:    result = a | b;
            OpNand:  result = ~(a & b);
            OpNor:   result = ~(a | b);
            OpXor:   result = a ^ b;
            OpXnor:  result = ~(a ^ b);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/gate_unit_arbiter.sv
// Round-robin arbiter sharing one basic_gate_alu among NUM_REQ requesters.
// Each grant runs capture (IDLE->EXEC edge), compute (EXEC), respond (RESP).
//   clk_in, rst_n_in : clock, asynchronous active-low reset
//   req_in           : per-requester request, held until ack
//   op_in/a_in/b_in  : per-requester opcode and operands (packed slices)
//   ack_out          : one-hot single-cycle pulse during RESP
//   result_out       : registered result, held until the next RESP
//   grant_id_out     : index of the current/last grantee
//   busy_out         : high in EXEC/RESP
//   op_count_out     : completed-op counter, only when GATE_ARB_STATS_EN is defined
module gate_unit_arbiter
    import gate_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    parameter  int unsigned DATA_W  = 8,
    localparam int unsigned GID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    input  logic [NUM_REQ-1:0]          req_in,
    input  logic [OP_W*NUM_REQ-1:0]     op_in,
    input  logic [DATA_W*NUM_REQ-1:0]   a_in,
    input  logic [DATA_W*NUM_REQ-1:0]   b_in,
    output logic [NUM_REQ-1:0]          ack_out,
    output logic [DATA_W-1:0]           result_out,
    output logic [GID_W-1:0]            grant_id_out,
`ifdef GATE_ARB_STATS_EN
    output logic [15:0]                 op_count_out,
`endif
    output logic                        busy_out
);

    arb_state_e        state_q, state_d;
    logic [GID_W-1:0]  grant_q, rr_q;
    gate_op_e          op_q;
    logic [DATA_W-1:0] a_q, b_q, result_q;
    logic [DATA_W-1:0] alu_result;

    // Round-robin pick: search rr_q+1 upward with wrap, ending at rr_q itself.
    logic              any_req;
    logic [GID_W-1:0]  pick;
    gate_op_e          pick_op;
    logic [DATA_W-1:0] pick_a, pick_b;
    int                idx;

    assign any_req = |req_in;

    always_comb begin
        pick    = '0;
        pick_op = OpNot;
        pick_a  = '0;
        pick_b  = '0;
        idx     = 0;
        for (int i = int'(NUM_REQ); i >= 1; i--) begin
            // Iterate from farthest to nearest so the nearest set bit wins last.
            idx = int'(rr_q) + i;
            if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
            if (req_in[idx]) begin
                pick    = GID_W'(idx);
                pick_op = gate_op_e'(op_in[idx*OP_W +: OP_W]);
                pick_a  = a_in[idx*DATA_W +: DATA_W];
                pick_b  = b_in[idx*DATA_W +: DATA_W];
            end
        end
    end

    basic_gate_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (alu_result)
    );

    // State register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state_q <= StIdle;
        else           state_q <= state_d;
    end

    // Next-state logic; unused encodings fall back to idle
    always_comb begin
        state_d = StIdle;
        case (state_q)
            StIdle:  state_d = any_req ? StExec : StIdle;
            StExec:  state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Capture, result and round-robin pointer registers
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            grant_q  <= '0;
            rr_q     <= GID_W'(NUM_REQ - 1);
            op_q     <= OpNot;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            if (state_q == StIdle && any_req) begin
                grant_q <= pick;
                op_q    <= pick_op;
                a_q     <= pick_a;
                b_q     <= pick_b;
            end
            if (state_q == StExec) result_q <= alu_result;
            if (state_q == StResp) rr_q     <= grant_q;
        end
    end

`ifdef GATE_ARB_STATS_EN
    logic [15:0] op_count_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)              op_count_q <= '0;
        else if (state_q == StResp) op_count_q <= op_count_q + 16'd1;
    end

    assign op_count_out = op_count_q;
`endif

    // Outputs
    always_comb begin
        ack_out = '0;
        if (state_q == StResp) ack_out[grant_q] = 1'b1;
        busy_out     = (state_q == StExec) || (state_q == StResp);
        result_out   = result_q;
        grant_id_out = grant_q;
    end

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Self-checking bench for gate_unit_arbiter (NUM_REQ=4, DATA_W=8): directed vector table,
// hand-written round-robin / reset / capture sequences, and a randomized run against a
// transaction-level reference model.
module tb_gate_unit_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;

    logic              clk_in = 1'b0;
    logic              rst_n_in;
    logic [NR-1:0]     req_in;
    logic [3*NR-1:0]   op_in;
    logic [DW*NR-1:0]  a_in, b_in;
    logic [NR-1:0]     ack_out;
    logic [DW-1:0]     result_out;
    logic [1:0]        grant_id_out;
    logic              busy_out;
`ifdef GATE_ARB_STATS_EN
    logic [15:0]       op_count_out;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_in = ~clk_in;

    gate_unit_arbiter #(
        .NUM_REQ (NR),
        .DATA_W  (DW)
    ) dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .req_in       (req_in),
        .op_in        (op_in),
        .a_in         (a_in),
        .b_in         (b_in),
        .ack_out      (ack_out),
        .result_out   (result_out),
        .grant_id_out (grant_id_out),
`ifdef GATE_ARB_STATS_EN
        .op_count_out (op_count_out),
`endif
        .busy_out     (busy_out)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference gate: per-bit truth table lookup indexed by {a,b}
    function automatic logic [DW-1:0] ref_gate(input int op, input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
        logic [3:0] tts [8];
        logic [3:0] tt;
        logic [DW-1:0] r;
        tts = '{4'b0011, 4'b1100, 4'b1000, 4'b1110, 4'b0111, 4'b0001, 4'b0110, 4'b1001};
        tt = tts[op];
        for (int i = 0; i < DW; i++) r[i] = tt[{a[i], b[i]}];
        return r;
    endfunction

    typedef struct {
        int         req;
        int         op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
        bit         chg;  // corrupt operand A right after the grant edge
    } vec_t;

    vec_t vecs[$];

    task automatic do_reset();
        req_in   = '0;
        rst_n_in = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        bit got;
        @(negedge clk_in);
        op_in[3*v.req +: 3]  = 3'(v.op);
        a_in[DW*v.req +: DW] = v.a;
        b_in[DW*v.req +: DW] = v.b;
        req_in[v.req]        = 1'b1;
        n   = 0;
        got = 1'b0;
        while (n < 10 && !got) begin
            @(negedge clk_in);
            n++;
            if (n == 1) begin
                check("busy_in_exec", busy_out, 1'b1);
                if (v.chg) a_in[DW*v.req +: DW] = ~v.a;
            end
            if (ack_out != '0) got = 1'b1;
        end
        check($sformatf("latency_req%0d_op%0d", v.req, v.op), n, 2);
        check($sformatf("ack_req%0d_op%0d", v.req, v.op), ack_out, NR'(1) << v.req);
        check($sformatf("result_req%0d_op%0d", v.req, v.op), result_out, v.exp);
        check($sformatf("grant_req%0d_op%0d", v.req, v.op), grant_id_out, v.req);
        req_in[v.req] = 1'b0;
    endtask

    // Randomized run state
    int          m_left, m_win, m_last, m_grant, m_ops;
    logic [DW-1:0] m_pend, m_exp_res;

    initial begin
        int order [$];
        int cyc   [$];
        int n;
        int seen;

        rst_n_in = 1'b0;
        req_in   = '0;
        op_in    = '0;
        a_in     = '0;
        b_in     = '0;
        #1;
        check("reset_ack", ack_out, '0);
        check("reset_result", result_out, '0);
        check("reset_grant", grant_id_out, '0);
        check("reset_busy", busy_out, 1'b0);
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;

        // Directed vectors
        vecs.push_back('{0, 2, 8'hF0, 8'h3C, 8'h30, 1'b0});
        vecs.push_back('{1, 0, 8'hA5, 8'h0F, 8'h5A, 1'b0});
        vecs.push_back('{1, 1, 8'hA5, 8'h0F, 8'hA5, 1'b0});
        vecs.push_back('{1, 2, 8'hA5, 8'h0F, 8'h05, 1'b0});
        vecs.push_back('{1, 3, 8'hA5, 8'h0F, 8'hAF, 1'b0});
        vecs.push_back('{1, 4, 8'hA5, 8'h0F, 8'hFA, 1'b0});
        vecs.push_back('{1, 5, 8'hA5, 8'h0F, 8'h50, 1'b0});
        vecs.push_back('{1, 6, 8'hA5, 8'h0F, 8'hAA, 1'b0});
        vecs.push_back('{1, 7, 8'hA5, 8'h0F, 8'h55, 1'b0});
        vecs.push_back('{2, 6, 8'hFF, 8'h00, 8'hFF, 1'b1});
        vecs.push_back('{3, 3, 8'h12, 8'h40, 8'h52, 1'b1});
        foreach (vecs[i]) run_vec(vecs[i]);

        // All four requesting from reset: served 0,1,2,3 every 3 cycles
        do_reset();
        @(negedge clk_in);
        for (int i = 0; i < NR; i++) begin
            op_in[3*i +: 3]  = 3'd1;
            a_in[DW*i +: DW] = 8'(8'h11 * (i + 1));
        end
        req_in = '1;
        n = 0;
        while (n < 40 && order.size() < NR) begin
            @(negedge clk_in);
            n++;
            for (int i = 0; i < NR; i++) begin
                if (ack_out[i]) begin
                    order.push_back(i);
                    cyc.push_back(n);
                    check($sformatf("rr_result%0d", i), result_out, 8'(8'h11 * (i + 1)));
                    req_in[i] = 1'b0;
                end
            end
        end
        check("rr_ack_count", order.size(), NR);
        for (int k = 0; k < order.size(); k++) begin
            check($sformatf("rr_order%0d", k), order[k], k);
            check($sformatf("rr_cycle%0d", k), cyc[k], 2 + 3 * k);
        end
        // Re-raise 0 and 2: pointer sits at 3, so 0 wins first
        @(negedge clk_in);
        req_in = 4'b0101;
        order.delete();
        n = 0;
        while (n < 20 && order.size() < 2) begin
            @(negedge clk_in);
            n++;
            for (int i = 0; i < NR; i++) begin
                if (ack_out[i]) begin
                    order.push_back(i);
                    req_in[i] = 1'b0;
                end
            end
        end
        check("rr2_ack_count", order.size(), 2);
        if (order.size() == 2) begin
            check("rr2_first", order[0], 0);
            check("rr2_second", order[1], 2);
        end

        // Async reset in EXEC, request withdrawn: no ack afterwards
        @(negedge clk_in);
        op_in[5:3] = 3'd2;
        a_in[15:8] = 8'hFF;
        b_in[15:8] = 8'hFF;
        req_in[1]  = 1'b1;
        @(posedge clk_in);
        #2;
        check("pre_reset_busy", busy_out, 1'b1);
        rst_n_in = 1'b0;
        #1;
        check("async_ack", ack_out, '0);
        check("async_result", result_out, '0);
        check("async_busy", busy_out, 1'b0);
        check("async_grant", grant_id_out, '0);
        req_in[1] = 1'b0;
        @(negedge clk_in);
        rst_n_in = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk_in);
            if (ack_out != '0) seen++;
        end
        check("no_ack_after_reset", seen, 0);

        // Async reset in EXEC with request held: re-served after release
        @(negedge clk_in);
        req_in[1] = 1'b1;
        @(posedge clk_in);
        #2;
        rst_n_in = 1'b0;
        #1;
        check("async2_busy", busy_out, 1'b0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        n = 0;
        while (n < 10 && ack_out == '0) begin
            @(negedge clk_in);
            n++;
        end
        check("reserve_ack", ack_out, 4'b0010);
        check("reserve_latency", n, 2);
        check("reserve_result", result_out, 8'hFF);
        req_in[1] = 1'b0;

        // Randomized run against a transaction-level model
        do_reset();
`ifdef GATE_ARB_STATS_EN
        check("stats_reset", op_count_out, 16'd0);
`endif
        m_left    = 0;
        m_win     = 0;
        m_last    = NR - 1;
        m_grant   = 0;
        m_ops     = 0;
        m_pend    = '0;
        m_exp_res = '0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk_in);
            check("rand_ack", ack_out, (m_left == 1) ? (NR'(1) << m_win) : NR'(0));
            check("rand_busy", busy_out, m_left > 0);
            check("rand_result", result_out, m_exp_res);
            check("rand_grant", grant_id_out, m_grant);
            if (m_left == 1) req_in[m_win] = 1'b0;
            for (int i = 0; i < NR; i++) begin
                if (m_left > 0 && i == m_win && req_in[i]) begin
                    // Already captured: these changes must not matter
                    op_in[3*i +: 3]  = 3'($urandom_range(7));
                    a_in[DW*i +: DW] = 8'($urandom);
                    b_in[DW*i +: DW] = 8'($urandom);
                end else if (!req_in[i] && !(m_left == 1 && i == m_win)
                             && $urandom_range(3) == 0) begin
                    op_in[3*i +: 3]  = 3'($urandom_range(7));
                    a_in[DW*i +: DW] = 8'($urandom);
                    b_in[DW*i +: DW] = 8'($urandom);
                    req_in[i]        = 1'b1;
                end
            end
            // Advance the model across the coming rising edge
            if (m_left == 0) begin
                for (int k = 1; k <= NR; k++) begin
                    if (m_left == 0 && req_in[(m_last + k) % NR]) begin
                        m_win   = (m_last + k) % NR;
                        m_grant = m_win;
                        m_pend  = ref_gate(int'(op_in[3*m_win +: 3]), a_in[DW*m_win +: DW],
                                           b_in[DW*m_win +: DW]);
                        m_left  = 2;
                    end
                end
            end else begin
                m_left--;
                if (m_left == 1) m_exp_res = m_pend;
                if (m_left == 0) begin
                    m_last = m_win;
                    m_ops++;
                end
            end
        end
`ifdef GATE_ARB_STATS_EN
        @(negedge clk_in);
        check("stats_count", op_count_out, 16'(m_ops));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
